// File: rtl/riscv_soft_mem_arbiter_pkg.sv
// Shared constants and types for the soft-core memory arbiter.
// Contents:
//   MEM_LOAD/MEM_STORE/MEM_FENCE  memory op encodings (existing core encodings)
//   MEM_OP_TYPE_WORD              funct3 for a full-word access
//   ARB_OWNER_I/ARB_OWNER_D       owner tag stored per in-flight request
//   arb_fence_e                   fence FSM states (idle / drain / ack)
//   ptr_width()                   FIFO pointer width, at least one bit
package riscv_soft_mem_arbiter_pkg;

  localparam logic [1:0] MEM_LOAD  = 2'd0;
  localparam logic [1:0] MEM_STORE = 2'd1;
  localparam logic [1:0] MEM_FENCE = 2'd2;

  localparam logic [2:0] MEM_OP_TYPE_WORD = 3'b010;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    ArbFenceIdle  = 2'b00,
    ArbFenceDrain = 2'b01,
    ArbFenceAck   = 2'b10
  } arb_fence_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/riscv_soft_owner_fifo.sv
// In-order 1-bit owner FIFO: records which requester owns each in-flight memory
// request so responses can be steered back in order.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   push_i, wdata_i      enqueue an owner tag (ignored when full)
//   pop_i                dequeue the head (ignored when empty)
//   rdata_o              owner tag at the head
//   empty_o, full_o      occupancy flags
//   count_o              number of entries held
module riscv_soft_owner_fifo
  import riscv_soft_mem_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = ptr_width(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            wdata_i,
  input  logic            pop_i,
  output logic            rdata_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o
);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  // Explicit wrap keeps the pointers correct for Depth == 1 as well.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(push_en) - CntW'(pop_en);
    if (push_en) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/riscv_soft_mem_arbiter.sv
// Shares one memory request/response port between the instruction-fetch side
// (i-side) and the data side (d-side). Requests and responses pass through with
// no added registers; an owner FIFO steers each in-order response back to its
// requester. d-side fences are absorbed locally: accepted, drained, then acked.
// Build option: define RISCV_SOFT_ARB_RR_EN for round-robin between i and d;
// otherwise the d-side always has priority over the i-side.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   i_req_* / i_resp_*              instruction-fetch request and response
//   d_req_* / d_resp_*              data load/store/fence request and response
//   mem_req_* / mem_resp_*          shared memory port
//   outstanding                     number of in-flight memory requests
module riscv_soft_mem_arbiter
  import riscv_soft_mem_arbiter_pkg::*;
#(
  parameter int unsigned XPR_LEN         = 32,
  parameter int unsigned ADDR_LEN        = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_req_valid,
  output logic                                 i_req_ready,
  input  logic [ADDR_LEN-1:0]                  i_req_addr,
  output logic                                 i_resp_valid,
  output logic [XPR_LEN-1:0]                   i_resp_data,
  input  logic                                 d_req_valid,
  output logic                                 d_req_ready,
  input  logic [ADDR_LEN-1:0]                  d_req_addr,
  input  logic [1:0]                           d_req_op,
  input  logic [2:0]                           d_req_op_type,
  input  logic [XPR_LEN-1:0]                   d_req_wdata,
  output logic                                 d_resp_valid,
  output logic [XPR_LEN-1:0]                   d_resp_data,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic [ADDR_LEN-1:0]                  mem_req_addr,
  output logic [1:0]                           mem_req_op,
  output logic [2:0]                           mem_req_op_type,
  output logic [XPR_LEN-1:0]                   mem_req_wdata,
  input  logic                                 mem_resp_valid,
  input  logic [XPR_LEN-1:0]                   mem_resp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  arb_fence_e fence_q, fence_d;
  logic       pri_d;
  logic       d_fence, d_mem;
  logic       grant_d, grant_i;
  logic       fence_idle, fence_take;
  logic       accept, pop;
  logic       drained;
  logic       fifo_head, fifo_empty, fifo_full;
  logic [CntW-1:0] fifo_count;

  assign outstanding = fifo_count;

  always_comb begin
    d_fence    = d_req_valid && (d_req_op == MEM_FENCE);
    d_mem      = d_req_valid && !d_fence;
    fence_idle = (fence_q == ArbFenceIdle);

    grant_d = d_mem && (pri_d || !i_req_valid);
    grant_i = i_req_valid && !grant_d;

    // A pending fence blocks the i-side even though it never reaches memory.
    mem_req_valid = !reset && fence_idle && !fifo_full && !d_fence && (grant_d || grant_i);
    fence_take    = !reset && fence_idle && d_fence;
    accept        = mem_req_valid && mem_req_ready;

    i_req_ready = accept && grant_i;
    d_req_ready = (accept && grant_d) || fence_take;

    mem_req_addr    = grant_d ? d_req_addr : i_req_addr;
    mem_req_op      = grant_d ? d_req_op : MEM_LOAD;
    mem_req_op_type = grant_d ? d_req_op_type : MEM_OP_TYPE_WORD;
    mem_req_wdata   = d_req_wdata;

    // Stray responses with nothing in flight are dropped.
    pop          = !reset && mem_resp_valid && !fifo_empty;
    i_resp_valid = pop && (fifo_head == ARB_OWNER_I);
    d_resp_valid = (pop && (fifo_head == ARB_OWNER_D)) || (!reset && fence_q == ArbFenceAck);
    i_resp_data  = mem_resp_data;
    d_resp_data  = mem_resp_data;

    // No pushes happen while draining, so count reaching zero next cycle
    // means empty now or the last entry popping now.
    drained = (fifo_count == '0) || ((fifo_count == CntW'(1)) && pop);

    fence_d = fence_q;
    unique case (fence_q)
      ArbFenceIdle:  if (fence_take) fence_d = ArbFenceDrain;
      ArbFenceDrain: if (drained) fence_d = ArbFenceAck;
      ArbFenceAck:   fence_d = ArbFenceIdle;
      default:       fence_d = ArbFenceIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fence_q <= ArbFenceIdle;
    end else begin
      fence_q <= fence_d;
    end
  end

`ifdef RISCV_SOFT_ARB_RR_EN
  logic pri_d_q, pri_d_d;

  assign pri_d = pri_d_q;

  // Only a contested accept moves priority, toward the side that lost.
  always_comb begin
    pri_d_d = pri_d_q;
    if (accept && i_req_valid && d_mem) begin
      pri_d_d = !grant_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pri_d_q <= 1'b1;
    end else begin
      pri_d_q <= pri_d_d;
    end
  end
`else
  assign pri_d = 1'b1;
`endif

  riscv_soft_owner_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (accept),
    .wdata_i (grant_d ? ARB_OWNER_D : ARB_OWNER_I),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

endmodule

// File: doc/riscv_soft_mem_arbiter.md
Name: riscv_soft_mem_arbiter

Overview:
- Shares one backing memory request/response port between the instruction-fetch requester (i-side) and the data requester (d-side, loads/stores/fences).
- Tracks the owner of every in-flight request in an in-order owner FIFO and steers each memory response back to its owner.
- Absorbs fences locally: it drains outstanding traffic, then acknowledges the fence.
- Sits between the core's i_cache/d_cache request interfaces and the single memory port.

Parameters:
- XPR_LEN, 32, data width of write/read data.
- ADDR_LEN, 32, request address width.
- MAX_OUTSTANDING, 2, owner FIFO depth; a power of 2, at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  instruction fetch request.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  ADDR_LEN  fetch address.
- i_resp_valid  out  1  fetch response pulse.
- i_resp_data  out  XPR_LEN  fetch data.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_addr  in  ADDR_LEN  data address.
- d_req_op  in  2  MEM_LOAD / MEM_STORE / MEM_FENCE.
- d_req_op_type  in  3  funct3 size/sign.
- d_req_wdata  in  XPR_LEN  store data.
- d_resp_valid  out  1  data response pulse (loads, stores, fences).
- d_resp_data  out  XPR_LEN  load data; don't-care for store/fence.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts this cycle.
- mem_req_addr  out  ADDR_LEN  forwarded address.
- mem_req_op  out  2  MEM_LOAD for i-side; d_req_op otherwise.
- mem_req_op_type  out  3  3'b010 (word) for i-side; d_req_op_type otherwise.
- mem_req_wdata  out  XPR_LEN  d_req_wdata.
- mem_resp_valid  in  1  memory response, in order, one per accepted request.
- mem_resp_data  in  XPR_LEN  response data.
- outstanding  out  clog2(MAX_OUTSTANDING+1)  in-flight request count.

Behaviour:
- Reset (async, reset=1): owner FIFO empty, outstanding=0, fence state = IDLE, pri_d=1. All *_valid and *_ready outputs are 0 while reset is asserted.
- full = (outstanding == MAX_OUTSTANDING).
- Grant is combinational:
  - d-side non-fence wins when pri_d=1 or i_req_valid=0.
  - Otherwise i-side wins.
- mem_req_valid = granted valid && !full && fence state IDLE; it never depends on mem_req_ready.
- Handshake:
  - Granted requester's ready = mem_req_ready && mem_req_valid.
  - Loser's ready = 0.
  - On accept, push the owner (ARB_OWNER_I/D) into the FIFO.
- Response routing: mem_resp_valid pops the FIFO head and pulses i_resp_valid or d_resp_valid in the same cycle (combinational steer), with data passed through.
- Responses have no backpressure. Both resp_valid outputs are never 1 in the same cycle, except in the FENCE case below.
- Simultaneous accept and response: push and pop both happen and outstanding is unchanged. This is legal when full, because the pop frees a slot only in the next cycle; full still blocks the accept that cycle.
- mem_resp_valid while the FIFO is empty (stray, e.g. after reset mid-transaction): dropped, no pulse, count stays 0.
- Fence FSM:
  - IDLE: on a d-side fence request, d_req_ready=1 and the FSM goes to DRAIN. Nothing is sent to memory. The fence request has priority over i-side.
  - DRAIN: no new grants to either side. When outstanding==0 (including the cycle the last response pops), go to ACK.
  - ACK: d_resp_valid=1 for exactly one cycle, then IDLE. In this cycle no mem response can be in flight.
- Fence issued with outstanding==0: accept cycle N, DRAIN at N+1 with immediate exit, d_resp_valid at N+2.
- Latency: request pass-through is 0 cycles, response pass-through is 0 cycles; arbiter adds no registers on the data path.
- Counter arithmetic is modular on the FIFO pointers (clog2(MAX_OUTSTANDING) bits, wrap-around). outstanding is a separate saturating-free up/down counter that is never allowed to exceed MAX_OUTSTANDING or go below 0.

Optional Feature:
- Macro: RISCV_SOFT_ARB_RR_EN.
- Defined: round-robin. After any accepted request while both sides were valid, pri_d is set to the value that favours the loser next.
- Undefined: pri_d is tied to 1, giving fixed data-side priority; i-side is served only when the d-side is idle.
- Fences always take priority over i-side regardless of the macro.

Decomposition:
- Shared constants in riscv_soft_constants.v: MEM_LOAD/MEM_STORE/MEM_FENCE (existing), new ARB_OWNER_I=1'b0, ARB_OWNER_D=1'b1, ARB_FENCE_IDLE/DRAIN/ACK 2-bit encodings.
- One sub-module: riscv_soft_owner_fifo (1-bit wide, MAX_OUTSTANDING deep, push/pop/empty/full/count).

Test Plan:
- Reset checks:
  - With reset held and all inputs valid: every valid/ready output is 0.
  - Deassert reset, then i_req_valid=1 addr=0x100, mem_req_ready=1 → mem_req_addr=0x100, op=MEM_LOAD, i_req_ready=1.
  - A response 2 cycles later carrying 0xDEADBEEF → i_resp_valid=1, i_resp_data=0xDEADBEEF, d_resp_valid=0.
- Contention: i and d both valid for 4 cycles, mem_req_ready=1, responses disabled:
  - Without the macro: d granted twice, then full blocks both.
  - With the macro: grants alternate d,i; outstanding=2, then both ready=0.
- Out-of-owner ordering: accept d-load then i-fetch; return 0x11 then 0x22 → d_resp_data=0x11 first, then i_resp_data=0x22.
- Fence drain: 2 outstanding, then a d fence → d_req_ready=1, no mem_req_valid while pending. After the 2nd response, d_resp_valid pulses exactly one cycle later; an i request waiting throughout is granted only after ACK.
- Simultaneous push/pop while outstanding=1: an accept and a response in the same cycle → outstanding stays 1 and the owner order is preserved.
- Reset mid-operation: assert reset with 2 outstanding, release, inject mem_resp_valid → no resp pulse, outstanding=0.
